// File: rtl/fb_pkg.sv
// ----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer AXI initiators (fb_reader, fb_writer).
//   AXI_RESP_OKAY : AXI OKAY response code
//   FB_ADDR_WIDTH : default framebuffer byte-address width
//   fb_addr_t     : framebuffer address at the default width
// ----------------------------------------------------------------------------
package fb_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int unsigned FB_ADDR_WIDTH = 20;

    typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. The head entry comes from storage written on an earlier
// edge, so there is no write-to-read fall-through. The head reads as zero
// while the FIFO is empty.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_wr_en     : push i_wr_data (ignored when full and not popping)
//   i_rd_en     : pop the head entry (ignored when empty)
//   o_rd_data   : head entry
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign w_pop     = i_rd_en & ~o_empty;
    // A full FIFO can still accept a push in the cycle its head is popped.
    assign w_push    = i_wr_en & (~o_full | w_pop);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (~w_push & w_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/fb_reader.sv
// ----------------------------------------------------------------------------
// fb_reader
// Framebuffer read initiator. Pixel read requests are turned into single-beat
// AXI reads; R beats are buffered and returned in request order on a
// valid/ready response stream. A credit counter bounds the requests in flight
// (accepted, not yet consumed) to DEPTH so every outstanding read has a FIFO
// slot and rready can be tied high.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr : pixel read request stream
//   resp_valid/resp_ready        : pixel response stream
//   resp_color                   : rdata[PIXEL_BITS-1:0]
//   resp_err                     : beat carried a non-OKAY rresp
//   sram_axi_ar*                 : AXI read address channel (master)
//   sram_axi_r*                  : AXI read data channel (master, rready = 1)
// Build option:
//   FB_READER_RRESP_CHECK_EN defined : rresp != OKAY is stored per entry and
//                                      presented on resp_err with its pixel.
//   undefined                        : resp_err tied 0, rresp ignored.
// ----------------------------------------------------------------------------
module fb_reader
    import fb_pkg::*;
#(
    parameter int unsigned PIXEL_BITS     = 16,
    parameter int unsigned AXI_ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [PIXEL_BITS-1:0]     resp_color,
    output logic                      resp_err,
    output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
    output logic                      sram_axi_arvalid,
    input  logic                      sram_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
    input  logic [1:0]                sram_axi_rresp,
    input  logic                      sram_axi_rvalid,
    output logic                      sram_axi_rready
);

    localparam int unsigned   CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
`ifdef FB_READER_RRESP_CHECK_EN
    localparam int unsigned   ENTRY_W    = PIXEL_BITS + 1;
`else
    localparam int unsigned   ENTRY_W    = PIXEL_BITS;
`endif

    logic [CW-1:0]             r_credits;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic                      r_arvalid;
    logic                      w_req_hs;
    logic                      w_resp_hs;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [ENTRY_W-1:0]        w_push_data;
    logic [ENTRY_W-1:0]        w_head;
    logic                      w_unused;

    // The AR slot must be free (or draining this cycle) for a new request.
    assign req_ready        = (r_credits != CREDIT_MAX) & (~r_arvalid | sram_axi_arready);
    assign w_req_hs         = req_valid & req_ready;
    assign w_resp_hs        = resp_valid & resp_ready;
    assign sram_axi_araddr  = r_araddr;
    assign sram_axi_arvalid = r_arvalid;
    assign sram_axi_rready  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= '0;
        end else if (w_req_hs & ~w_resp_hs) begin
            r_credits <= r_credits + CW'(1);
        end else if (~w_req_hs & w_resp_hs) begin
            r_credits <= r_credits - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
        end else if (w_req_hs) begin
            r_araddr  <= req_addr;
            r_arvalid <= 1'b1;
        end else if (sram_axi_arready) begin
            r_arvalid <= 1'b0;
        end
    end

`ifdef FB_READER_RRESP_CHECK_EN
    assign w_push_data = {(sram_axi_rresp != AXI_RESP_OKAY), sram_axi_rdata[PIXEL_BITS-1:0]};
    assign resp_err    = w_head[PIXEL_BITS];
    assign w_unused    = w_fifo_full;
`else
    assign w_push_data = sram_axi_rdata[PIXEL_BITS-1:0];
    assign resp_err    = 1'b0;
    assign w_unused    = ^{w_fifo_full, sram_axi_rresp};
`endif

    if (AXI_DATA_WIDTH > PIXEL_BITS) begin : g_rdata_upper
        logic w_unused_upper;
        assign w_unused_upper = ^sram_axi_rdata[AXI_DATA_WIDTH-1:PIXEL_BITS];
    end

    assign resp_valid = ~w_fifo_empty;
    assign resp_color = w_head[PIXEL_BITS-1:0];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (sram_axi_rvalid),
        .i_wr_data (w_push_data),
        .i_rd_en   (resp_ready),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // An R beat with no request in flight means the slave broke the protocol.
    a_r_in_window: assert property (
        @(posedge clk) disable iff (!rst_n) sram_axi_rvalid |-> (r_credits != '0)
    );

endmodule

// File: tb/tb_fb_reader.sv
module tb_fb_reader;

    localparam int unsigned PB    = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [PB-1:0] resp_color;
    logic          resp_err;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    always #5 clk = ~clk;

    fb_reader #(
        .PIXEL_BITS     (PB),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .DEPTH          (DEPTH)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_color       (resp_color),
        .resp_err         (resp_err),
        .sram_axi_araddr  (araddr),
        .sram_axi_arvalid (arvalid),
        .sram_axi_arready (arready),
        .sram_axi_rdata   (rdata),
        .sram_axi_rresp   (rresp),
        .sram_axi_rvalid  (rvalid),
        .sram_axi_rready  (rready)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference memory and error map of the modelled SRAM slave.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hABDD ^ {a[19:16], 12'h000};
    endfunction

    function automatic logic err_f(input logic [AW-1:0] a);
        return a[3:0] == 4'hB;
    endfunction

    // Reference model state.
    logic [PB-1:0] exp_color[$];
    logic          exp_err[$];
    logic [AW-1:0] ar_q[$];     // accepted, not yet issued on AR
    logic [AW-1:0] sl_addr[$];  // issued on AR, R beat not yet returned
    int            sl_due[$];
    int            accepted = 0;
    int            popped   = 0;
    int            rbeats   = 0;
    int            ar_hs_cnt = 0;
    int            last_due = 0;
    int            cyc      = 0;

    // Stimulus knobs.
    int            req_pct, ar_pct, rr_pct, lat_min, lat_max, req_left;
    bit            seq_addr;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] addr_step;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_model();
        exp_color.delete();
        exp_err.delete();
        ar_q.delete();
        sl_addr.delete();
        sl_due.delete();
        accepted = 0;
        popped   = 0;
        rbeats   = 0;
        last_due = 0;
        req_left = 0;
    endtask

    // One clock of stimulus plus the cycle-level protocol checks.
    task automatic cycle();
        int            lat;
        int            due;
        logic [AW-1:0] a;
        @(negedge clk);
        chk("arvalid", arvalid, ar_q.size() > 0);
        if (ar_q.size() > 0) chk("araddr", araddr, ar_q[0]);
        chk("resp_valid", resp_valid, (rbeats - popped) > 0);
        chk("credits", u_dut.r_credits, accepted - popped);
        chk("rready", rready, 1);

        arready    = ($urandom_range(99) < ar_pct);
        resp_ready = ($urandom_range(99) < rr_pct);
        if (sl_addr.size() > 0 && sl_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_f(sl_addr[0]);
            rresp  = err_f(sl_addr[0]) ? (sl_addr[0][4] ? 2'b11 : 2'b10) : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = DW'($urandom);
            rresp  = 2'($urandom);
        end
        if (req_left > 0 && $urandom_range(99) < req_pct) begin
            req_valid = 1'b1;
            req_addr  = seq_addr ? next_addr : AW'($urandom);
        end else begin
            req_valid = 1'b0;
            req_addr  = AW'($urandom);
        end
        #1;
        chk("req_ready", req_ready,
            ((accepted - popped) != DEPTH) && (ar_q.size() == 0 || arready));

        if (rvalid) begin
            void'(sl_addr.pop_front());
            void'(sl_due.pop_front());
            rbeats++;
        end
        if (arvalid && arready && ar_q.size() > 0) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            sl_addr.push_back(ar_q.pop_front());
            sl_due.push_back(due);
            ar_hs_cnt++;
        end
        if (req_valid && req_ready) begin
            a = req_addr;
            ar_q.push_back(a);
            exp_color.push_back(mem_f(a));
`ifdef FB_READER_RRESP_CHECK_EN
            exp_err.push_back(err_f(a));
`else
            exp_err.push_back(1'b0);
`endif
            accepted++;
            req_left--;
            next_addr = next_addr + addr_step;
        end
    endtask

    // Scoreboard monitor: checks each response the DUT hands over.
    always @(negedge clk) begin
        #2;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_color.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got color 0x%0h, expected no response", resp_color);
            end else begin
                chk("resp_color", resp_color, exp_color.pop_front());
                chk("resp_err", resp_err, exp_err.pop_front());
            end
            popped++;
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((req_left > 0 || accepted != popped) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (req_left > 0 || accepted != popped), 0);
    endtask

    task automatic set_mode(input int rq, input int ar, input int rr, input int lmin,
                            input int lmax);
        req_pct = rq;
        ar_pct  = ar;
        rr_pct  = rr;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rvalid     = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_color"}, resp_color, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_credits"}, u_dut.r_credits, 0);
    endtask

    int a0, p0, h0;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        set_mode(100, 100, 100, 1, 1);
        seq_addr  = 1'b1;
        addr_step = AW'(1);
        next_addr = '0;
        #1;
        check_reset_state("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single read of 0x00010 (slave data 0xABCD, latency 1).
        next_addr = AW'('h10);
        req_left  = 1;
        drain(50);
        chk("single_credits", u_dut.r_credits, 0);

        // Streaming: 16 sequential reads, all accepted back to back.
        next_addr = '0;
        req_left  = 16;
        a0        = accepted;
        repeat (16) cycle();
        chk("stream_accepted", accepted - a0, 16);
        drain(100);

        // Backpressure: consumer stalled, only DEPTH requests fit.
        set_mode(100, 100, 0, 1, 1);
        next_addr = AW'('h100);
        req_left  = 6;
        a0        = accepted;
        p0        = popped;
        repeat (20) cycle();
        chk("bp_accepted", accepted - a0, 4);
        chk("bp_req_ready", req_ready, 0);
        set_mode(100, 100, 100, 1, 1);
        drain(100);
        chk("bp_returned", popped - p0, 6);

        // AR stall: address held while arready is low.
        set_mode(100, 0, 100, 1, 1);
        next_addr = AW'('h2345);
        req_left  = 1;
        h0        = ar_hs_cnt;
        repeat (6) cycle();
        chk("stall_arvalid", arvalid, 1);
        chk("stall_araddr", araddr, 'h2345);
        chk("stall_req_ready", req_ready, 0);
        set_mode(100, 100, 100, 1, 1);
        drain(50);
        chk("stall_ar_count", ar_hs_cnt - h0, 1);

        // Error response on the second of three reads.
        next_addr = AW'('h300);
        addr_step = AW'('hB);
        req_left  = 3;
        drain(50);
        addr_step = AW'(1);

        // Randomized traffic.
        set_mode(60, 70, 70, 1, 3);
        seq_addr = 1'b0;
        req_left = 1000;
        repeat (400) cycle();
        req_left = 0;
        set_mode(100, 100, 100, 1, 3);
        drain(200);

        // Reset with three reads in flight.
        set_mode(100, 100, 100, 5, 5);
        seq_addr  = 1'b1;
        next_addr = AW'('h500);
        req_left  = 3;
        repeat (4) cycle();
        chk("pre_reset_credits", u_dut.r_credits, 3);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_state("midrst");
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_mode(100, 100, 100, 1, 1);
        next_addr = AW'('h510);
        req_left  = 1;
        p0        = popped;
        drain(50);
        chk("post_reset_returned", popped - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
